argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of class scores per input vector (range 1..64).
REQ-002 Parameter DATA_WIDTH, default 16, bits per class score.
REQ-003 Parameter SIGNED, default 1, 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 Derived constant CLASS_W = max(1, ceil(log2(NUM_CLASSES))).
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_data holds a valid score vector.
REQ-008 in_ready  output  1  block accepts a vector this cycle.
REQ-009 in_data  input  NUM_CLASSES*DATA_WIDTH  score k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_class  output  CLASS_W  index of winning class.
REQ-013 out_max  output  DATA_WIDTH  winning score.
REQ-014 out_tie  output  1  another class equals the winning score.
REQ-015 hex  output  7  active-low seven-segment pattern {g,f,e,d,c,b,a} of out_class.

Function
REQ-016 FSM states IDLE, SCAN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE, in_valid=1: register full in_data, best_idx=0, best_val=score0, tie=0, idx=1; go SCAN (NUM_CLASSES>1) or DONE (NUM_CLASSES=1).
REQ-018 SCAN, one score per cycle: score[idx] > best_val -> best_idx=idx, best_val=score[idx], tie=0; score[idx] == best_val -> tie=1; else unchanged.
REQ-019 SCAN: idx increments each cycle; after comparing idx = NUM_CLASSES-1, go DONE next edge.
REQ-020 Latency: out_valid rises NUM_CLASSES cycles after the accepting edge (10 cycles at default).
REQ-021 Ties: strict greater-than; lowest index wins; out_tie reports equality with the final winner only.
REQ-022 Compare is signed when SIGNED=1, unsigned when SIGNED=0; full DATA_WIDTH, no truncation.
REQ-023 out_class, out_max, out_tie, hex load on the edge entering DONE; held stable until the next entry to DONE, including through IDLE/SCAN.
REQ-024 DONE: remain until out_ready=1; on out_valid&&out_ready go IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-025 in_data changes during SCAN/DONE have no effect (captured copy used).
REQ-026 hex encoding: classes 0-9 standard digits (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000), 10-15 hex A,b,C,d,E,F, >15 = 0111111 (dash).

Reset
REQ-027 reset=0 asynchronously forces IDLE, idx=0, out_valid=0, out_class=0, out_max=0, out_tie=0, hex=1110111.
REQ-028 Reset during SCAN or DONE discards the vector in progress; no out_valid after release until a new accepted vector completes.
REQ-029 in_ready=1 on the first clock edge after reset release.

Verification
REQ-030 Default params, scores 0..9 = {3,-5,7,2,7,0,-1,6,1,4} -> out_class=2, out_max=7, out_tie=1, hex=0100100, out_valid at cycle 10.
REQ-031 Scores all -100 except class 9 = -99 -> out_class=9, out_tie=0, hex=0011000 (signed compare).
REQ-032 SIGNED=0, score1=16'hFFFF, rest 1 -> out_class=1, out_max=16'hFFFF.
REQ-033 out_ready held 0 for 20 cycles in DONE -> out_valid and fields stable, in_ready=0; release -> in_ready=1 one cycle after handshake.
REQ-034 reset pulsed at SCAN cycle 4 -> hex=1110111, out_valid=0, in_ready=1 after release; next vector completes normally.
REQ-035 NUM_CLASSES=1, score0=42 -> out_valid one cycle after accept, out_class=0, out_max=42, out_tie=0.

Source files
------------

// File: rtl/argmax_classifier.sv
// Streaming argmax: captures a vector of class scores, scans one score per
// cycle and reports the winning class index, its score, a tie flag and a
// seven-segment pattern of the winning index.
module argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SIGNED      = 1,
  localparam int unsigned CLASS_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CLASS_W-1:0]                out_class,
  output logic [DATA_WIDTH-1:0]             out_max,
  output logic                              out_tie,
  output logic [6:0]                        hex
);

  localparam int unsigned IDX_W = CLASS_W + 1;
  localparam int unsigned SLOTS = 1 << CLASS_W;
  localparam int unsigned VEC_W = NUM_CLASSES * DATA_WIDTH;
  localparam logic [6:0]  HEX_RESET = 7'b1110111;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e state_q, state_d;

  logic [VEC_W-1:0]      data_q, data_d;
  logic [CLASS_W-1:0]    best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic                  tie_q, tie_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]    out_class_q, out_class_d;
  logic [DATA_WIDTH-1:0] out_max_q, out_max_d;
  logic                  out_tie_q, out_tie_d;
  logic [6:0]            hex_q, hex_d;

  logic [DATA_WIDTH-1:0] scores [SLOTS];
  logic [DATA_WIDTH-1:0] score_sel;
  logic                  score_gt;
  logic                  score_eq;

  // Active-low {g,f,e,d,c,b,a} glyph for a class index; dash beyond 15
  function automatic logic [6:0] seg7(input logic [CLASS_W-1:0] cls);
    logic [6:0] v;
    v = 7'(cls);
    case (v)
      7'd0:    seg7 = 7'b1000000;
      7'd1:    seg7 = 7'b1111001;
      7'd2:    seg7 = 7'b0100100;
      7'd3:    seg7 = 7'b0110000;
      7'd4:    seg7 = 7'b0011001;
      7'd5:    seg7 = 7'b0010010;
      7'd6:    seg7 = 7'b0000010;
      7'd7:    seg7 = 7'b1111000;
      7'd8:    seg7 = 7'b0000000;
      7'd9:    seg7 = 7'b0011000;
      7'd10:   seg7 = 7'b0001000;
      7'd11:   seg7 = 7'b0000011;
      7'd12:   seg7 = 7'b1000110;
      7'd13:   seg7 = 7'b0100001;
      7'd14:   seg7 = 7'b0000110;
      7'd15:   seg7 = 7'b0001110;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  // Unpack the captured vector; slots past NUM_CLASSES pad the index space
  for (genvar k = 0; k < SLOTS; k++) begin : g_unpack
    if (k < NUM_CLASSES) begin : g_live
      assign scores[k] = data_q[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign scores[k] = '0;
    end
  end

  assign score_sel = scores[idx_q[CLASS_W-1:0]];
  assign score_eq  = (score_sel == best_val_q);
  assign score_gt  = (SIGNED != 0) ? ($signed(score_sel) > $signed(best_val_q))
                                   : (score_sel > best_val_q);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; idx runs one past the last class so the final compare
  // settles before DONE is entered
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = (NUM_CLASSES == 1) ? DONE : SCAN;
      SCAN:    if (idx_q == IDX_W'(NUM_CLASSES)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    data_d      = data_q;
    best_idx_d  = best_idx_q;
    best_val_d  = best_val_q;
    tie_d       = tie_q;
    idx_d       = idx_q;
    out_class_d = out_class_q;
    out_max_d   = out_max_q;
    out_tie_d   = out_tie_q;
    hex_d       = hex_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          best_idx_d = '0;
          best_val_d = in_data[DATA_WIDTH-1:0];
          tie_d      = 1'b0;
          idx_d      = IDX_W'(1);
          if (NUM_CLASSES == 1) begin
            out_class_d = '0;
            out_max_d   = in_data[DATA_WIDTH-1:0];
            out_tie_d   = 1'b0;
            hex_d       = seg7(CLASS_W'(0));
          end
        end
      end
      SCAN: begin
        if (idx_q < IDX_W'(NUM_CLASSES)) begin
          if (score_gt) begin
            best_idx_d = idx_q[CLASS_W-1:0];
            best_val_d = score_sel;
            tie_d      = 1'b0;
          end else if (score_eq) begin
            tie_d = 1'b1;
          end
          idx_d = idx_q + IDX_W'(1);
        end else begin
          out_class_d = best_idx_q;
          out_max_d   = best_val_q;
          out_tie_d   = tie_q;
          hex_d       = seg7(best_idx_q);
          idx_d       = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      tie_q       <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_max_q   <= '0;
      out_tie_q   <= 1'b0;
      hex_q       <= HEX_RESET;
    end else begin
      data_q      <= data_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      tie_q       <= tie_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_max_q   <= out_max_d;
      out_tie_q   <= out_tie_d;
      hex_q       <= hex_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_max   = out_max_q;
  assign out_tie   = out_tie_q;
  assign hex       = hex_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: default signed instance, an unsigned
// instance and a single-class instance share one clock and reset.
module tb_argmax_classifier;

  logic clock;
  logic reset;

  // Default parameters (10 classes, 16-bit, signed)
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_tie_a;
  logic [159:0] in_data_a;
  logic [3:0]   out_class_a;
  logic [15:0]  out_max_a;
  logic [6:0]   hex_a;

  // Unsigned compare
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_tie_b;
  logic [159:0] in_data_b;
  logic [3:0]   out_class_b;
  logic [15:0]  out_max_b;
  logic [6:0]   hex_b;

  // Single class
  logic         in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_tie_c;
  logic [15:0]  in_data_c;
  logic [0:0]   out_class_c;
  logic [15:0]  out_max_c;
  logic [6:0]   hex_c;

  int n_cmp = 0;
  int n_bad = 0;

  argmax_classifier u_dut_a (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_class(out_class_a), .out_max(out_max_a), .out_tie(out_tie_a), .hex(hex_a)
  );

  argmax_classifier #(.SIGNED(0)) u_dut_b (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_class(out_class_b), .out_max(out_max_b), .out_tie(out_tie_b), .hex(hex_b)
  );

  argmax_classifier #(.NUM_CLASSES(1)) u_dut_c (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_class(out_class_c), .out_max(out_max_c), .out_tie(out_tie_c), .hex(hex_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one vector to instance a, then scramble in_data and count cycles to out_valid
  task automatic run_a(input int sv [10], output int lat);
    for (int k = 0; k < 10; k++) in_data_a[k*16 +: 16] = 16'(sv[k]);
    in_valid_a = 1'b1;
    @(posedge clock); #1;
    in_valid_a = 1'b0;
    in_data_a  = {10{16'h7FFF}};
    lat = 0;
    while (!out_valid_a && lat < 64) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  // Complete the output handshake on instance a
  task automatic handshake_a();
    out_ready_a = 1'b1;
    @(posedge clock); #1;
    out_ready_a = 1'b0;
    chk("hs_valid_low", 32'(out_valid_a), 32'd0);
    chk("hs_ready_high", 32'(in_ready_a), 32'd1);
  endtask

  initial begin
    int vec [10];
    int lat;
    int seen;

    reset = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    in_valid_c = 1'b0; out_ready_c = 1'b0; in_data_c = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_class", 32'(out_class_a), 32'd0);
    chk("rst_max", 32'(out_max_a), 32'd0);
    chk("rst_tie", 32'(out_tie_a), 32'd0);
    chk("rst_hex", 32'(hex_a), 32'(7'b1110111));
    #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("rel_in_ready", 32'(in_ready_a), 32'd1);

    // Mixed signed scores with a tie on the winner
    vec = '{3, -5, 7, 2, 7, 0, -1, 6, 1, 4};
    run_a(vec, lat);
    chk("v1_latency", 32'(lat), 32'd10);
    chk("v1_class", 32'(out_class_a), 32'd2);
    chk("v1_max", 32'(out_max_a), 32'd7);
    chk("v1_tie", 32'(out_tie_a), 32'd1);
    chk("v1_hex", 32'(hex_a), 32'(7'b0100100));

    // Back-pressure: everything holds while out_ready is low
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      chk("hold_stable",
          32'({out_valid_a, in_ready_a, out_class_a, out_max_a, out_tie_a, hex_a}),
          32'({1'b1, 1'b0, 4'd2, 16'd7, 1'b1, 7'b0100100}));
    end
    handshake_a();
    chk("idle_hold_class", 32'(out_class_a), 32'd2);

    // Negative scores, unique winner at the last class
    vec = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -99};
    run_a(vec, lat);
    chk("v2_class", 32'(out_class_a), 32'd9);
    chk("v2_max", 32'(out_max_a), 32'(16'hFF9D));
    chk("v2_tie", 32'(out_tie_a), 32'd0);
    chk("v2_hex", 32'(hex_a), 32'(7'b0011000));
    handshake_a();

    // Earlier tie cleared by a later strictly greater score
    vec = '{1, 4, 4, 9, 0, 0, 0, 0, 0, 0};
    run_a(vec, lat);
    chk("v3_class", 32'(out_class_a), 32'd3);
    chk("v3_max", 32'(out_max_a), 32'd9);
    chk("v3_tie", 32'(out_tie_a), 32'd0);
    chk("v3_hex", 32'(hex_a), 32'(7'b0110000));
    handshake_a();

    // Reset in the middle of a scan
    vec = '{3, -5, 7, 2, 7, 0, -1, 6, 1, 4};
    for (int k = 0; k < 10; k++) in_data_a[k*16 +: 16] = 16'(vec[k]);
    in_valid_a = 1'b1;
    @(posedge clock); #1;
    in_valid_a = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    #2;
    chk("mid_rst_hex", 32'(hex_a), 32'(7'b1110111));
    chk("mid_rst_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_class", 32'(out_class_a), 32'd0);
    #2 reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (out_valid_a) seen++;
    end
    chk("no_stale_valid", 32'(seen), 32'd0);
    chk("post_rst_ready", 32'(in_ready_a), 32'd1);
    run_a(vec, lat);
    chk("v4_latency", 32'(lat), 32'd10);
    chk("v4_class", 32'(out_class_a), 32'd2);
    chk("v4_tie", 32'(out_tie_a), 32'd1);
    handshake_a();

    // Unsigned compare: 0xFFFF is the largest value
    for (int k = 0; k < 10; k++) in_data_b[k*16 +: 16] = 16'd1;
    in_data_b[31:16] = 16'hFFFF;
    in_valid_b = 1'b1;
    @(posedge clock); #1;
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 64) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("u_latency", 32'(lat), 32'd10);
    chk("u_class", 32'(out_class_b), 32'd1);
    chk("u_max", 32'(out_max_b), 32'(16'hFFFF));
    chk("u_tie", 32'(out_tie_b), 32'd0);

    // Single class: result right after the accepting edge
    chk("n1_idle_valid", 32'(out_valid_c), 32'd0);
    in_data_c  = 16'd42;
    in_valid_c = 1'b1;
    @(posedge clock); #1;
    in_valid_c = 1'b0;
    chk("n1_valid", 32'(out_valid_c), 32'd1);
    chk("n1_in_ready", 32'(in_ready_c), 32'd0);
    chk("n1_class", 32'(out_class_c), 32'd0);
    chk("n1_max", 32'(out_max_c), 32'd42);
    chk("n1_tie", 32'(out_tie_c), 32'd0);
    chk("n1_hex", 32'(hex_c), 32'(7'b1000000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
